// File: rtl/fwd_hazard_if.sv
// Operand-forwarding / load-use hazard bus between the ID stage and fwd_hazard_unit.
// The master drives ID-stage metadata; the slave returns forwarding selects and stall.
interface fwd_hazard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  hold;
  logic                  flush;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  stall;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      fwd_cnt;

  modport master (
    output hold, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read,
    input  fwd_a, fwd_b, stall, stall_cnt, fwd_cnt
  );

  modport slave (
    input  hold, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read,
    output fwd_a, fwd_b, stall, stall_cnt, fwd_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for the 5-stage RV32I pipeline.
// Optional statistics counters are built only when FWD_HAZARD_STATS_EN is defined.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  fwd_hazard_if.slave  hz
);

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_WB = 2'b01,
    FWD_EX = 2'b10
  } fwd_sel_e;

  logic                  ex_v, ex_wr, ex_ld;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mem_v, mem_wr;
  logic [REG_ADDR_W-1:0] mem_rd;
  fwd_sel_e              fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic load_use, bubble;

  // A hit means the slot writes a non-x0 register that ID actually reads.
  always_comb begin
    ex_hit1  = hz.id_use_rs1 && ex_v  && ex_wr  && (ex_rd  == hz.id_rs1) && (hz.id_rs1 != '0);
    ex_hit2  = hz.id_use_rs2 && ex_v  && ex_wr  && (ex_rd  == hz.id_rs2) && (hz.id_rs2 != '0);
    mem_hit1 = hz.id_use_rs1 && mem_v && mem_wr && (mem_rd == hz.id_rs1) && (hz.id_rs1 != '0);
    mem_hit2 = hz.id_use_rs2 && mem_v && mem_wr && (mem_rd == hz.id_rs2) && (hz.id_rs2 != '0);
    load_use = hz.id_valid && ex_ld && (ex_hit1 || ex_hit2);
    bubble   = hz.flush || load_use || !hz.id_valid;
  end

  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!bubble) begin
      if (ex_hit1)       fwd_a_d = FWD_EX;
      else if (mem_hit1) fwd_a_d = FWD_WB;
      if (ex_hit2)       fwd_b_d = FWD_EX;
      else if (mem_hit2) fwd_b_d = FWD_WB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v    <= 1'b0;
      ex_wr   <= 1'b0;
      ex_ld   <= 1'b0;
      ex_rd   <= '0;
      mem_v   <= 1'b0;
      mem_wr  <= 1'b0;
      mem_rd  <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (!hz.hold) begin
      mem_v  <= ex_v;
      mem_wr <= ex_wr;
      mem_rd <= ex_rd;
      if (bubble) begin
        ex_v  <= 1'b0;
        ex_wr <= 1'b0;
        ex_ld <= 1'b0;
        ex_rd <= '0;
      end else begin
        ex_v  <= 1'b1;
        ex_wr <= hz.id_reg_write;
        ex_ld <= hz.id_mem_read;
        ex_rd <= hz.id_rd;
      end
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign hz.fwd_a = fwd_a_q;
  assign hz.fwd_b = fwd_b_q;
  assign hz.stall = load_use;

`ifdef FWD_HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (!hz.hold) begin
      if (load_use && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      // One count per cycle even when both operands forward.
      if (((fwd_a_d != FWD_RF) || (fwd_b_d != FWD_RF)) && (fwd_cnt_q != '1))
        fwd_cnt_q <= fwd_cnt_q + 1'b1;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.fwd_cnt   = fwd_cnt_q;
`else
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  assign hz.stall_cnt = CNT_ZERO;
  assign hz.fwd_cnt   = CNT_ZERO;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vector table, hand-written
// reset/hold sequences, then randomized traffic against an instruction-history model.
module tb_fwd_hazard_unit;

  logic clk;
  logic rst_n;

  fwd_hazard_if #(.REG_ADDR_W(5), .CNT_W(16)) hz ();

  fwd_hazard_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit flush, hold, v;
    int rs1, rs2;
    bit u1, u2;
    int rd;
    bit wr, ld;
    int ea, eb;
    bit es;
  } row_t;

  // Instructions that left ID, youngest first; a bubble is recorded as invalid.
  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } rec_t;

  rec_t hist[$];
  int   m_a, m_b, m_sc, m_fc;
  int   passed, total;
  row_t tbl[$];

  function automatic row_t mk(bit flush, bit hold, bit v, int rs1, int rs2, bit u1, bit u2,
                              int rd, bit wr, bit ld, int ea, int eb, bit es);
    row_t r;
    r.flush = flush; r.hold = hold; r.v = v;
    r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
    r.rd = rd; r.wr = wr; r.ld = ld;
    r.ea = ea; r.eb = eb; r.es = es;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic bit writes(rec_t r, int reg_idx);
    return r.v && r.wr && (r.rd == reg_idx) && (reg_idx != 0);
  endfunction

  function automatic bit m_stall();
    if (!hz.id_valid || hist.size() == 0) return 1'b0;
    return hist[0].ld &&
           ((hz.id_use_rs1 && writes(hist[0], int'(hz.id_rs1))) ||
            (hz.id_use_rs2 && writes(hist[0], int'(hz.id_rs2))));
  endfunction

  // Nearest producer wins: distance 1 (EX) -> 2, distance 2 (MEM) -> 1.
  function automatic int m_sel(int rs, bit use_rs);
    if (!hz.id_valid || hz.flush || m_stall() || !use_rs) return 0;
    for (int d = 0; d < hist.size(); d++)
      if (writes(hist[d], rs)) return (d == 0) ? 2 : 1;
    return 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_a = 0; m_b = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic model_edge();
    int na, nb;
    rec_t rec;
    if (hz.hold) return;
    na = m_sel(int'(hz.id_rs1), hz.id_use_rs1);
    nb = m_sel(int'(hz.id_rs2), hz.id_use_rs2);
    if (m_stall() && m_sc < 65535) m_sc++;
    if ((na != 0 || nb != 0) && m_fc < 65535) m_fc++;
    if (!hz.id_valid || hz.flush || m_stall()) begin
      rec.v = 0; rec.rd = 0; rec.wr = 0; rec.ld = 0;
    end else begin
      rec.v = 1; rec.rd = int'(hz.id_rd); rec.wr = hz.id_reg_write; rec.ld = hz.id_mem_read;
    end
    hist.push_front(rec);
    if (hist.size() > 2) void'(hist.pop_back());
    m_a = na;
    m_b = nb;
  endtask

  task automatic apply(input row_t r);
    hz.flush        = r.flush;
    hz.hold         = r.hold;
    hz.id_valid     = r.v;
    hz.id_rs1       = r.rs1[4:0];
    hz.id_rs2       = r.rs2[4:0];
    hz.id_use_rs1   = r.u1;
    hz.id_use_rs2   = r.u2;
    hz.id_rd        = r.rd[4:0];
    hz.id_reg_write = r.wr;
    hz.id_mem_read  = r.ld;
  endtask

  task automatic check_cnts(input string nm);
`ifdef FWD_HAZARD_STATS_EN
    chk({nm, ".stall_cnt"}, int'(hz.stall_cnt), m_sc);
    chk({nm, ".fwd_cnt"},   int'(hz.fwd_cnt),   m_fc);
`else
    chk({nm, ".stall_cnt"}, int'(hz.stall_cnt), 0);
    chk({nm, ".fwd_cnt"},   int'(hz.fwd_cnt),   0);
`endif
  endtask

  // One clock: drive after negedge, check stall combinationally, check selects after posedge.
  task automatic step(input string nm, input row_t r, input bit use_model);
    int ea, eb, es;
    @(negedge clk);
    apply(r);
    #1;
    es = use_model ? int'(m_stall()) : int'(r.es);
    chk({nm, ".stall"}, int'(hz.stall), es);
    model_edge();
    @(posedge clk);
    #1;
    ea = use_model ? m_a : r.ea;
    eb = use_model ? m_b : r.eb;
    chk({nm, ".fwd_a"}, int'(hz.fwd_a), ea);
    chk({nm, ".fwd_b"}, int'(hz.fwd_b), eb);
    check_cnts(nm);
  endtask

  initial begin
    row_t r;
    passed = 0;
    total  = 0;
    model_reset();
    r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(r);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.fwd_a", int'(hz.fwd_a), 0);
    chk("reset.fwd_b", int'(hz.fwd_b), 0);
    chk("reset.stall", int'(hz.stall), 0);
    check_cnts("reset");
    @(negedge clk);
    rst_n = 1'b1;

    //            fl ho v rs1 rs2 u1 u2 rd wr ld  ea eb es
    tbl.push_back(mk(0, 0, 1, 1,  2,  1, 1, 3, 1, 0, 0, 0, 0)); // add x3
    tbl.push_back(mk(0, 0, 1, 3,  3,  1, 1, 4, 1, 0, 2, 2, 0)); // sub x4,x3,x3
    tbl.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0)); // nop
    tbl.push_back(mk(0, 0, 1, 1,  2,  1, 1, 3, 1, 0, 0, 0, 0)); // add x3
    tbl.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0)); // nop
    tbl.push_back(mk(0, 0, 1, 3,  0,  1, 1, 5, 1, 0, 1, 0, 0)); // or x5,x3,x0
    tbl.push_back(mk(0, 0, 1, 1,  2,  1, 1, 3, 1, 0, 0, 0, 0)); // add x3
    tbl.push_back(mk(0, 0, 1, 1,  2,  1, 1, 3, 1, 0, 0, 0, 0)); // add x3
    tbl.push_back(mk(0, 0, 1, 3,  3,  1, 1, 6, 1, 0, 2, 2, 0)); // and x6,x3,x3
    tbl.push_back(mk(0, 0, 1, 2,  0,  1, 0, 7, 1, 1, 0, 0, 0)); // lw x7
    tbl.push_back(mk(0, 0, 1, 7,  1,  1, 1, 8, 1, 0, 0, 0, 1)); // add x8,x7,x1 (stall)
    tbl.push_back(mk(0, 0, 1, 7,  1,  1, 1, 8, 1, 0, 1, 0, 0)); // add x8 re-presented
    tbl.push_back(mk(0, 0, 1, 1,  0,  1, 0, 0, 1, 0, 0, 0, 0)); // addi x0,x1
    tbl.push_back(mk(0, 0, 1, 0,  0,  1, 1, 9, 1, 0, 0, 0, 0)); // reader of x0
    tbl.push_back(mk(0, 0, 1, 1,  2,  1, 1, 9, 1, 0, 0, 0, 0)); // add x9
    tbl.push_back(mk(1, 0, 1, 9,  9,  1, 1,10, 1, 0, 0, 0, 0)); // flushed x10 reader of x9
    tbl.push_back(mk(0, 0, 1,10,  9,  1, 1,11, 1, 0, 0, 1, 0)); // x10 not forwarded, x9 from MEM
    tbl.push_back(mk(0, 0, 1, 1,  0,  1, 0,11, 1, 1, 0, 0, 0)); // lw x11
    tbl.push_back(mk(1, 0, 1,11,  0,  1, 0,12, 1, 0, 0, 0, 1)); // flush + load-use
    tbl.push_back(mk(0, 0, 1,11,  0,  1, 0,12, 1, 0, 1, 0, 0)); // load now in MEM
    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i], 1'b0);

    // hold during an EX/MEM dependency
    step("hold.prod", mk(0, 0, 1, 1, 2, 1, 1, 12, 1, 0, 0, 0, 0), 1'b0);
    step("hold.dep",  mk(0, 0, 1,12,12, 1, 1, 13, 1, 0, 2, 2, 0), 1'b0);
    for (int i = 0; i < 3; i++)
      step($sformatf("hold.frz%0d", i), mk(0, 1, 1, 13, 1, 1, 1, 14, 1, 0, 2, 2, 0), 1'b0);
    step("hold.resume", mk(0, 0, 1, 13, 1, 1, 1, 14, 1, 0, 2, 0, 0), 1'b0);
    step("hold.after",  mk(0, 0, 1, 12, 1, 1, 1, 15, 1, 0, 0, 0, 0), 1'b0);

    // hold while a load-use hazard is pending
    step("hldld.lw", mk(0, 0, 1, 1, 0, 1, 0, 16, 1, 1, 0, 0, 0), 1'b0);
    for (int i = 0; i < 2; i++)
      step($sformatf("hldld.frz%0d", i), mk(0, 1, 1, 16, 2, 1, 1, 17, 1, 0, 0, 0, 1), 1'b0);
    step("hldld.stall", mk(0, 0, 1, 16, 2, 1, 1, 17, 1, 0, 0, 0, 1), 1'b0);
    step("hldld.fwd",   mk(0, 0, 1, 16, 2, 1, 1, 17, 1, 0, 1, 0, 0), 1'b0);

    // asynchronous reset in the middle of a cycle with a load in EX
    step("rst.prod", mk(0, 0, 1, 1, 2, 1, 1, 21, 1, 0, 0, 0, 0), 1'b0);
    step("rst.lw",   mk(0, 0, 1,21, 0, 1, 0, 20, 1, 1, 2, 0, 0), 1'b0);
    @(negedge clk);
    apply(mk(0, 0, 1, 20, 0, 1, 0, 22, 1, 0, 0, 0, 0));
    #1;
    chk("rst.pre_stall", int'(hz.stall), 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst.fwd_a", int'(hz.fwd_a), 0);
    chk("rst.fwd_b", int'(hz.fwd_b), 0);
    chk("rst.stall", int'(hz.stall), 0);
    check_cnts("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("rst.first", mk(0, 0, 1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0), 1'b0);

    // randomized traffic against the history model
    for (int i = 0; i < 400; i++) begin
      r = mk($urandom_range(9) == 0, $urandom_range(6) == 0, $urandom_range(7) != 0,
             $urandom_range(7), $urandom_range(7), $urandom_range(3) != 0, $urandom_range(3) != 0,
             $urandom_range(7), $urandom_range(4) != 0, $urandom_range(2) == 0, 0, 0, 0);
      step($sformatf("rnd%0d", i), r, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Sequential forwarding and hazard controller for the 5-stage RV32I pipeline.
- Tracks destination-register metadata of instructions in EX and MEM in internal shadow registers.
- Produces registered 2-bit selects that drive the ALU-operand 3-input muxes in EX: 00 = register file, 01 = MEM/WB result, 10 = EX/MEM result.
- Detects load-use hazards, raises a one-cycle stall, and inserts a bubble.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 16, width of statistics counters; used only with the optional feature.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  freezes all internal state; used for memory wait.
- flush  in  1  squash the instruction leaving ID (taken branch or jump).
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_ADDR_W  ID source register 1.
- id_rs2  in  REG_ADDR_W  ID source register 2.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_rd  in  REG_ADDR_W  ID destination register.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- fwd_a  out  2  registered select for ALU operand A mux in EX.
- fwd_b  out  2  registered select for ALU operand B mux in EX.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- stall_cnt  out  CNT_W  load-use stall count (optional feature).
- fwd_cnt  out  CNT_W  forwarding event count (optional feature).

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous and active-low.
- Reset values:
  - All shadow valid bits = 0.
  - All shadow rd fields = 0.
  - fwd_a = fwd_b = 00.
  - stall_cnt = fwd_cnt = 0.
  - stall = 0 follows combinationally, because the EX shadow is invalid.
- Shadow state: EX slot {ex_v, ex_rd, ex_wr, ex_ld}; MEM slot {mem_v, mem_rd, mem_wr}.
- A slot "writes R" when v = 1, wr = 1, rd = R and R != 0. Register x0 is never forwarded and never causes a stall.
- load_use = id_valid & ex_v & ex_ld & ex_wr & ex_rd != 0 & ((id_use_rs1 & ex_rd == id_rs1) | (id_use_rs2 & ex_rd == id_rs2)).
- stall = load_use. It is combinational, with zero latency, and is independent of hold and flush.
- bubble = flush | load_use | !id_valid.
- Update on each rising edge with hold = 0:
  - MEM slot <= EX slot.
  - EX slot <= all-zero if bubble, else {1, id_rd, id_reg_write, id_mem_read}.
  - fwd_a <= 00 if bubble. Otherwise 10 if the EX slot writes id_rs1 and id_use_rs1; else 01 if the MEM slot writes id_rs1 and id_use_rs1; else 00.
  - fwd_b: same rule using id_rs2 and id_use_rs2.
  - EX/MEM (code 10) always has priority over MEM/WB (code 01).
- Latency: fwd_a/fwd_b are valid exactly one cycle after the instruction was presented in ID, i.e. the cycle it occupies EX.
- Load-use sequence:
  - Cycle N: stall = 1 and a bubble enters EX.
  - Cycle N+1: the load sits in the MEM slot and ID re-presents the dependent instruction; stall = 0 and the select is computed as 01.
- hold = 1: every register keeps its value (shadows, fwd_*, counters). stall is still driven from current state and inputs.
- flush together with load_use: treated as a bubble; stall still asserts as computed.
- Code 11 is never produced.
- Reset asserted mid-operation: all state clears immediately and asynchronously. The first instruction after reset release never forwards.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- Defined:
  - stall_cnt increments on each edge with hold = 0 and load_use = 1.
  - fwd_cnt increments on each edge with hold = 0 where the next fwd_a or fwd_b is non-zero. It increments by 1 per cycle, even if both operands forward.
  - Both counters saturate at 2^CNT_W - 1.
- Not defined: counter logic is absent and stall_cnt = fwd_cnt = 0 constant. Ports remain so that instantiations are unchanged.

Test Plan:
- Reset: rst_n = 0 mid-stream with EX slot valid -> fwd_a = fwd_b = 00 and stall = 0 immediately; after release, first instruction rs1 = 5 with no producer gives fwd_a = 00.
- EX/MEM forward: add x3 then sub x4,x3,x3 back-to-back -> in sub's EX cycle fwd_a = fwd_b = 10, stall = 0.
- MEM/WB forward and priority:
  - add x3; nop; or x5,x3,x0 -> fwd_a = 01, fwd_b = 00.
  - add x3; add x3; and x6,x3,x3 -> fwd_a = fwd_b = 10 (younger producer wins).
- Load-use: lw x7; add x8,x7,x1 -> stall = 1 for exactly one cycle, then add in EX with fwd_a = 01, fwd_b = 00; stall_cnt = 1 when FWD_HAZARD_STATS_EN is defined.
- x0 and flush:
  - addi x0 producer followed by a reader of x0 -> fwd = 00.
  - flush = 1 on a dependent instruction -> next fwd = 00 and the EX slot is invalid; a following reader of that rd does not forward.
- hold: assert hold = 1 for 3 cycles during an EX/MEM dependency -> fwd_a stays 10 and the shadows are frozen; after release, the sequence resumes identically to the no-hold run.
